// File: rtl/latch_bank_sequencer.sv
// latch_bank_sequencer
// Round-robin write sequencer for a shared bank of single-bit D latches.
// Each write runs SETUP -> ENABLE -> HOLD so the shared data line is stable
// around the one-hot enable pulse; a bank-wide clear runs through latch_reset
// and always wins over pending writes at the next IDLE.
module latch_bank_sequencer #(
   parameter int NUM_REQ   = 4,
   parameter int NUM_LATCH = 8,
   parameter int SETUP_CYC = 1,
   parameter int EN_CYC    = 2,
   parameter int HOLD_CYC  = 1,
   parameter int RST_CYC   = 2,
   localparam int AW = $clog2(NUM_LATCH),
   localparam int GW = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ*AW-1:0] req_addr,
   input  logic [NUM_REQ-1:0]    req_data,
   output logic [NUM_REQ-1:0]    ack,
   input  logic                  clr_req,
   output logic                  clr_ack,
   output logic                  busy,
   output logic [GW-1:0]         grant_id,
   output logic                  latch_d,
   output logic [NUM_LATCH-1:0]  latch_e,
   output logic                  latch_reset
);

   // Phase counter must hold the longest phase length minus one.
   localparam int M1   = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
   localparam int M2   = (HOLD_CYC > RST_CYC) ? HOLD_CYC : RST_CYC;
   localparam int MAXC = (M1 > M2) ? M1 : M2;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic [2:0] {IDLE, SETUP, ENABLE, HOLD, CLEAR} state_t;

   state_t               state_reg, state_next;
   logic [CW-1:0]        cnt_reg, cnt_next;
   logic [GW-1:0]        rr_reg, rr_next;
   logic                 pend_reg, pend_next;
   logic [GW-1:0]        gid_reg, gid_next;
   logic [AW-1:0]        addr_reg, addr_next;
   logic                 latch_d_reg, latch_d_next;
   logic [NUM_LATCH-1:0] latch_e_reg, latch_e_next;
   logic                 latch_reset_reg, latch_reset_next;
   logic [NUM_REQ-1:0]   ack_reg, ack_next;
   logic                 clr_ack_reg, clr_ack_next;
   logic                 busy_reg, busy_next;

   logic [NUM_LATCH-1:0] e_dec;
   logic [NUM_REQ-1:0]   ack_dec;
   logic [NUM_REQ-1:0]   req_avail;
   logic                 win_found;
   logic [GW-1:0]        win_idx;
   int                   arb_sum;
   logic [GW-1:0]        arb_cand;

   // Decode the captured address; out-of-range addresses match no bit.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_LATCH; gi++) begin : g_e_dec
         assign e_dec[gi] = (addr_reg == AW'(gi));
      end
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_ack_dec
         assign ack_dec[gi] = (gid_reg == GW'(gi));
      end
   endgenerate

   // The requester being acked this cycle cannot win again, so a late drop
   // of its req never produces a second grant.
   assign req_avail = req & ~ack_reg;

   // Round-robin search starting at the rr pointer.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      arb_sum   = 0;
      arb_cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         arb_sum = int'(rr_reg) + k;
         if (arb_sum >= NUM_REQ) begin
            arb_sum = arb_sum - NUM_REQ;
         end
         arb_cand = GW'(arb_sum);
         if (!win_found && req_avail[arb_cand]) begin
            win_found = 1'b1;
            win_idx   = arb_cand;
         end
      end
   end

   // Next-state and next-output logic; outputs are registered from these.
   always_comb begin
      state_next       = state_reg;
      cnt_next         = cnt_reg + 1'b1;
      rr_next          = rr_reg;
      pend_next        = pend_reg | (clr_req & (state_reg != IDLE));
      gid_next         = gid_reg;
      addr_next        = addr_reg;
      latch_d_next     = latch_d_reg;
      latch_e_next     = '0;
      latch_reset_next = 1'b0;
      ack_next         = '0;
      clr_ack_next     = 1'b0;
      case (state_reg)
         IDLE: begin
            cnt_next = '0;
            if (clr_req || pend_reg) begin
               // The pending request is consumed on entry; a clr_req seen
               // while clearing re-arms it for exactly one more clear.
               state_next       = CLEAR;
               pend_next        = 1'b0;
               latch_reset_next = 1'b1;
            end else if (win_found) begin
               state_next   = SETUP;
               gid_next     = win_idx;
               addr_next    = req_addr[int'(win_idx)*AW +: AW];
               latch_d_next = req_data[win_idx];
            end
         end
         SETUP: begin
            if (cnt_reg == CW'(SETUP_CYC - 1)) begin
               state_next   = ENABLE;
               cnt_next     = '0;
               latch_e_next = e_dec;
            end
         end
         ENABLE: begin
            latch_e_next = e_dec;
            if (cnt_reg == CW'(EN_CYC - 1)) begin
               state_next   = HOLD;
               cnt_next     = '0;
               latch_e_next = '0;
            end
         end
         HOLD: begin
            if (cnt_reg == CW'(HOLD_CYC - 1)) begin
               state_next = IDLE;
               cnt_next   = '0;
               ack_next   = ack_dec;
               rr_next    = (gid_reg == GW'(NUM_REQ - 1)) ? '0 : gid_reg + 1'b1;
            end
         end
         CLEAR: begin
            latch_reset_next = 1'b1;
            if (cnt_reg == CW'(RST_CYC - 1)) begin
               state_next       = IDLE;
               cnt_next         = '0;
               latch_reset_next = 1'b0;
               clr_ack_next     = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
      busy_next = (state_next != IDLE);
   end

   // State and registered outputs; reset forces everything low immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg       <= IDLE;
         cnt_reg         <= '0;
         rr_reg          <= '0;
         pend_reg        <= 1'b0;
         gid_reg         <= '0;
         addr_reg        <= '0;
         latch_d_reg     <= 1'b0;
         latch_e_reg     <= '0;
         latch_reset_reg <= 1'b0;
         ack_reg         <= '0;
         clr_ack_reg     <= 1'b0;
         busy_reg        <= 1'b0;
      end else begin
         state_reg       <= state_next;
         cnt_reg         <= cnt_next;
         rr_reg          <= rr_next;
         pend_reg        <= pend_next;
         gid_reg         <= gid_next;
         addr_reg        <= addr_next;
         latch_d_reg     <= latch_d_next;
         latch_e_reg     <= latch_e_next;
         latch_reset_reg <= latch_reset_next;
         ack_reg         <= ack_next;
         clr_ack_reg     <= clr_ack_next;
         busy_reg        <= busy_next;
      end
   end

   assign ack         = ack_reg;
   assign clr_ack     = clr_ack_reg;
   assign busy        = busy_reg;
   assign grant_id    = gid_reg;
   assign latch_d     = latch_d_reg;
   assign latch_e     = latch_e_reg;
   assign latch_reset = latch_reset_reg;

endmodule

// File: tb/tb_latch_bank_sequencer.sv
// Directed bench for latch_bank_sequencer: single write, round-robin order,
// clear priority, async reset mid-write, address boundaries and data freeze.
// A second instance with 6 latches exercises an out-of-range address.
module tb_latch_bank_sequencer;
   localparam int NR  = 4;
   localparam int NL  = 8;
   localparam int NL2 = 6;
   localparam int AW  = 3;
   localparam int GW  = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic [NR-1:0]   req, req_data, ack;
   logic [NR*AW-1:0] req_addr;
   logic            clr_req, clr_ack, busy, latch_d, latch_reset;
   logic [GW-1:0]   grant_id;
   logic [NL-1:0]   latch_e;

   logic [NR-1:0]   req2, req_data2, ack2;
   logic [NR*AW-1:0] req_addr2;
   logic            clr_req2, clr_ack2, busy2, latch_d2, latch_reset2;
   logic [GW-1:0]   grant_id2;
   logic [NL2-1:0]  latch_e2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   latch_bank_sequencer dut (
      .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
      .req_data(req_data), .ack(ack), .clr_req(clr_req), .clr_ack(clr_ack),
      .busy(busy), .grant_id(grant_id), .latch_d(latch_d),
      .latch_e(latch_e), .latch_reset(latch_reset)
   );

   latch_bank_sequencer #(.NUM_LATCH(NL2)) dut2 (
      .clk(clk), .reset(reset), .req(req2), .req_addr(req_addr2),
      .req_data(req_data2), .ack(ack2), .clr_req(clr_req2), .clr_ack(clr_ack2),
      .busy(busy2), .grant_id(grant_id2), .latch_d(latch_d2),
      .latch_e(latch_e2), .latch_reset(latch_reset2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_addr(input int r, input int a);
      req_addr[r*AW +: AW] = AW'(a);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 30 && busy; i++) tick();
      chk("idle_timeout", {31'd0, busy}, 0);
      tick();
   endtask

   initial begin
      int last;
      int n;
      int waited;
      logic [NR-1:0] drop;

      reset = 1'b1; req = '0; req_data = '0; req_addr = '0; clr_req = 1'b0;
      req2 = '0; req_data2 = '0; req_addr2 = '0; clr_req2 = 1'b0;
      tick(); tick();
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_latch_e", {24'd0, latch_e}, 0);
      chk("rst_latch_d", {31'd0, latch_d}, 0);
      chk("rst_ack", {28'd0, ack}, 0);
      chk("rst_grant", {30'd0, grant_id}, 0);
      chk("rst_latch_reset", {31'd0, latch_reset}, 0);
      chk("rst_clr_ack", {31'd0, clr_ack}, 0);
      reset = 1'b0;
      tick();

      // Single write: requester 2, addr 5, data 1
      req[2] = 1'b1; set_addr(2, 5); req_data[2] = 1'b1;
      tick();
      chk("sw_c1_busy", {31'd0, busy}, 1);
      chk("sw_c1_d", {31'd0, latch_d}, 1);
      chk("sw_c1_e", {24'd0, latch_e}, 0);
      tick();
      chk("sw_c2_e", {24'd0, latch_e}, 32'h20);
      chk("sw_c2_ack", {28'd0, ack}, 0);
      tick();
      chk("sw_c3_e", {24'd0, latch_e}, 32'h20);
      chk("sw_c3_d", {31'd0, latch_d}, 1);
      tick();
      chk("sw_c4_e", {24'd0, latch_e}, 0);
      chk("sw_c4_d", {31'd0, latch_d}, 1);
      chk("sw_c4_ack", {28'd0, ack}, 0);
      tick();
      chk("sw_c5_ack", {28'd0, ack}, 32'h4);
      chk("sw_c5_grant", {30'd0, grant_id}, 2);
      chk("sw_c5_busy", {31'd0, busy}, 0);
      $display("single write: req 2 addr 5 data 1 ack=%b grant=%0d", ack, grant_id);
      req[2] = 1'b0;
      tick();
      chk("sw_c6_ack", {28'd0, ack}, 0);
      chk("sw_c6_d_kept", {31'd0, latch_d}, 1);

      // Round-robin with all four requesters; pointer starts at 0 after reset
      reset = 1'b1; tick(); reset = 1'b0; tick();
      for (int r = 0; r < NR; r++) begin
         set_addr(r, r); req_data[r] = r[0];
      end
      req = 4'b1111; last = 0; n = 0; drop = '0;
      for (int c = 1; c <= 27; c++) begin
         tick();
         if (drop != '0) begin
            req = req | drop;
            drop = '0;
         end
         if (ack != '0) begin
            chk("rr_ack", {28'd0, ack}, 32'd1 << (n % NR));
            chk("rr_grant", {30'd0, grant_id}, n % NR);
            chk("rr_gap", c - last, 5);
            $display("round-robin: ack=%b grant=%0d cycle=%0d", ack, grant_id, c);
            last = c; n++;
            req = req & ~ack;
            drop = ack;
         end
      end
      chk("rr_count", n, 5);
      req = '0;
      wait_idle();

      // Clear requested during ENABLE of a write to addr 3
      req[1] = 1'b1; set_addr(1, 3); req_data[1] = 1'b1;
      tick();
      tick();
      chk("clr_c2_e", {24'd0, latch_e}, 32'h08);
      clr_req = 1'b1;
      req[3] = 1'b1; set_addr(3, 6); req_data[3] = 1'b0;
      tick();
      clr_req = 1'b0;
      tick();
      chk("clr_c4_rst", {31'd0, latch_reset}, 0);
      tick();
      chk("clr_c5_ack", {28'd0, ack}, 32'h2);
      chk("clr_c5_rst", {31'd0, latch_reset}, 0);
      $display("clear test write: ack=%b grant=%0d", ack, grant_id);
      req[1] = 1'b0;
      tick();
      chk("clr_c6_rst", {31'd0, latch_reset}, 1);
      chk("clr_c6_e", {24'd0, latch_e}, 0);
      chk("clr_c6_busy", {31'd0, busy}, 1);
      tick();
      chk("clr_c7_rst", {31'd0, latch_reset}, 1);
      chk("clr_c7_clr_ack", {31'd0, clr_ack}, 0);
      tick();
      chk("clr_c8_clr_ack", {31'd0, clr_ack}, 1);
      chk("clr_c8_rst", {31'd0, latch_reset}, 0);
      chk("clr_c8_busy", {31'd0, busy}, 0);
      $display("clear: clr_ack=%b", clr_ack);
      tick();
      chk("clr_c9_busy", {31'd0, busy}, 1);
      chk("clr_c9_grant", {30'd0, grant_id}, 3);
      chk("clr_c9_d", {31'd0, latch_d}, 0);
      tick(); tick(); tick(); tick();
      chk("clr_c13_ack", {28'd0, ack}, 32'h8);
      $display("post-clear write: ack=%b grant=%0d", ack, grant_id);
      req[3] = 1'b0;
      tick();

      // Async reset while latch_e[1] is high
      req[0] = 1'b1; set_addr(0, 1); req_data[0] = 1'b1;
      tick(); tick();
      chk("ar_c2_e", {24'd0, latch_e}, 32'h02);
      #3;
      reset = 1'b1;
      #1;
      chk("ar_e", {24'd0, latch_e}, 0);
      chk("ar_d", {31'd0, latch_d}, 0);
      chk("ar_busy", {31'd0, busy}, 0);
      chk("ar_ack", {28'd0, ack}, 0);
      @(posedge clk);
      #3;
      reset = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         tick();
         if (c == 2) chk("ar_re_e", {24'd0, latch_e}, 32'h02);
         if (c < 5) chk("ar_re_noack", {28'd0, ack}, 0);
         else chk("ar_re_ack", {28'd0, ack}, 32'h1);
      end
      $display("restart after reset: ack=%b grant=%0d", ack, grant_id);
      req[0] = 1'b0;
      tick();

      // Top address and pointer wrap 3 -> 0
      req[3] = 1'b1; set_addr(3, NL - 1); req_data[3] = 1'b0;
      tick(); tick();
      chk("top_c2_e", {24'd0, latch_e}, 32'h80);
      chk("top_c2_d", {31'd0, latch_d}, 0);
      tick(); tick(); tick();
      chk("top_c5_ack", {28'd0, ack}, 32'h8);
      $display("top address write: ack=%b grant=%0d", ack, grant_id);
      req = 4'b1010;
      tick();
      req = 4'b0010;
      chk("wrap_grant", {30'd0, grant_id}, 1);
      waited = 0;
      while (ack == '0 && waited < 10) begin
         tick();
         waited++;
      end
      chk("wrap_ack", {28'd0, ack}, 32'h2);
      $display("wrap write: ack=%b grant=%0d", ack, grant_id);
      req = '0;
      tick();

      // Captured addr/data stay frozen after the grant
      req[2] = 1'b1; set_addr(2, 4); req_data[2] = 1'b1;
      tick();
      req_data[2] = 1'b0; set_addr(2, 6);
      chk("frz_c1_d", {31'd0, latch_d}, 1);
      tick();
      chk("frz_c2_e", {24'd0, latch_e}, 32'h10);
      chk("frz_c2_d", {31'd0, latch_d}, 1);
      tick();
      chk("frz_c3_e", {24'd0, latch_e}, 32'h10);
      tick();
      chk("frz_c4_d", {31'd0, latch_d}, 1);
      tick();
      chk("frz_c5_ack", {28'd0, ack}, 32'h4);
      $display("frozen write: ack=%b grant=%0d", ack, grant_id);
      req[2] = 1'b0;
      tick();

      // Out-of-range address on the 6-latch instance
      req2[0] = 1'b1; req_addr2[AW-1:0] = 3'd6; req_data2[0] = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         tick();
         if (c == 2) chk("oor_busy", {31'd0, busy2}, 1);
         if (c < 5) chk("oor_e", {26'd0, latch_e2}, 0);
         else chk("oor_ack", {28'd0, ack2}, 32'h1);
      end
      $display("out-of-range write: ack=%b", ack2);
      req2 = '0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/latch_bank_sequencer.md
Name: latch_bank_sequencer

Overview:
- Shares a bank of NUM_LATCH single-bit D latches (ports d, e, reset; outputs q, q_bar) between NUM_REQ requesters.
- Arbitrates write requests round-robin and drives one common latch_d line plus a one-hot enable vector.
- Sequences every write as SETUP -> ENABLE -> HOLD, so d is stable around the enable pulse.
- Also sequences a bank-wide clear through the latches' reset input. Sits between the requesting logic and the latch bank.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- NUM_LATCH, 8, number of latches in the bank (>=2); AW = $clog2(NUM_LATCH).
- SETUP_CYC, 1, cycles latch_d is driven before enable (>=1).
- EN_CYC, 2, cycles the selected latch_e bit is high (>=1).
- HOLD_CYC, 1, cycles latch_d is held after enable drops (>=1).
- RST_CYC, 2, cycles latch_reset is high during a clear (>=1).

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-high reset.
- req, in, NUM_REQ: write request per requester; level, held until ack.
- req_addr, in, NUM_REQ*AW: target latch index, slice i belongs to requester i.
- req_data, in, NUM_REQ: data bit per requester.
- ack, out, NUM_REQ: one-cycle completion pulse to the granted requester.
- clr_req, in, 1: bank clear request, single-cycle pulse or level.
- clr_ack, out, 1: one-cycle pulse when the clear completes.
- busy, out, 1: high in any state other than IDLE.
- grant_id, out, $clog2(NUM_REQ): index of the current or last granted requester.
- latch_d, out, 1: shared data line to all latch d inputs.
- latch_e, out, NUM_LATCH: one-hot latch enables.
- latch_reset, out, 1: drives all latch reset inputs.

Behaviour:
- All outputs are registered.
- Reset (async, any time, including mid-transaction): state=IDLE, all outputs 0, rr pointer=0, pending-clear flag=0. No latch_e may glitch high.
- FSM states: IDLE, SETUP, ENABLE, HOLD, CLEAR.
- IDLE:
  - If clr_req is high or the pending-clear flag is set -> CLEAR (clear beats writes).
  - Else if any req bit is unmasked -> pick the winner round-robin starting at the rr pointer, then capture grant_id, addr and data; go to SETUP.
  - Else stay in IDLE.
- SETUP (SETUP_CYC cycles): latch_d = captured data, latch_e = 0.
- ENABLE (EN_CYC cycles): latch_e[addr] = 1, all other bits 0, latch_d unchanged.
- HOLD (HOLD_CYC cycles): latch_e = 0, latch_d unchanged.
- Leaving HOLD: ack[grant_id] = 1 for exactly one cycle (the first IDLE cycle). rr pointer = grant_id+1, wrapping NUM_REQ-1 -> 0.
- Re-arbitration mask: in the cycle ack is high, the acked requester is excluded from arbitration, so a late req drop never causes a double grant. Other requesters may win in that same cycle.
- Latency: req seen at IDLE edge t -> ack high at t+SETUP_CYC+EN_CYC+HOLD_CYC+1 (defaults: t+5).
- Back-to-back writes: the gap between successive acks is exactly SETUP_CYC+EN_CYC+HOLD_CYC+1 cycles.
- Captured addr and data are frozen after the grant; later changes on req_addr/req_data have no effect.
- latch_d keeps its last value in IDLE until the next grant or reset.
- Out-of-range addr (>= NUM_LATCH): full sequence runs, latch_e stays all-zero, ack is still returned.
- CLEAR (RST_CYC cycles): latch_reset = 1, latch_e = 0. Then clr_ack pulses for 1 cycle, pending flag is cleared, return to IDLE. The rr pointer is unchanged.
- clr_req during SETUP/ENABLE/HOLD/CLEAR sets the pending flag. The current transaction is never aborted; the clear runs at the next IDLE.
- clr_req arriving during CLEAR causes exactly one further clear.
- busy = (state != IDLE).
- Invariant: at most one latch_e bit is high; latch_e and latch_reset are never high together.

Test Plan:
- Single write: reset, then req[2]=1, addr=5, data=1 at cycle 0. Expect SETUP at cycle 1, latch_e=8'b0010_0000 in cycles 2-3, latch_d=1 in cycles 1-4, ack=4'b0100 in cycle 5 only, grant_id=2.
- Round-robin: req=4'b1111 held (each requester drops on its own ack and re-raises next cycle). Grant order 0,1,2,3,0 with acks spaced 5 cycles apart. No requester is granted twice in a row while others wait.
- Clear priority and pending: clr_req pulse during ENABLE of a write to addr 3. The write completes (ack at t+5), then latch_reset=1 for 2 cycles, clr_ack pulses, and only then is the next req granted.
- Async reset mid-ENABLE: assert reset between clock edges while latch_e[1]=1. latch_e, latch_d, busy and ack go to 0 immediately with no ack issued. After release, req still high restarts the sequence from IDLE.
- Boundary: addr=NUM_LATCH (out of range) -> latch_e stays 0 through the sequence and ack arrives at t+5. Also check addr=NUM_LATCH-1 -> latch_e[7]=1, and the pointer wraps 3 -> 0.
- Data freeze: change req_data and req_addr during SETUP. latch_d and the asserted latch_e bit reflect the values captured at grant.
